banked_ram_ctrl: RTL and testbench
==================================

# banked_ram_ctrl

Parametrised, banked single-port RAM with a registered read port, a read-valid strobe and a post-reset clear engine. Words are spread over 2^BANK_SEL_W banks of 2^BANK_ADDR_W words each; the upper address bits select the bank and the lower bits select the word within it. After every reset, all banks are zeroed in parallel before any access is accepted. It supersedes the fixed 4K×16 bank-tree memory as the generic word store for the datapath.

## Interface
- DATA_W, 16: word width in bits.
- BANK_ADDR_W, 9: word-offset bits per bank (bank depth = 2^BANK_ADDR_W).
- BANK_SEL_W, 3: bank-select bits (bank count = 2^BANK_SEL_W; total depth = 2^(BANK_SEL_W+BANK_ADDR_W)).

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- e  in  1  chip enable; no access occurs when low.
- w  in  1  write request (qualified by e).
- r  in  1  read request (qualified by e).
- adr  in  BANK_SEL_W+BANK_ADDR_W  word address; bank = adr[MSB -: BANK_SEL_W], offset = adr[BANK_ADDR_W-1:0].
- din  in  DATA_W  write data.
- dout  out  DATA_W  registered read data; holds the last read value.
- dout_valid  out  1  one-cycle pulse when dout is updated by a read.
- busy  out  1  high while the clear engine runs; requests are not accepted.
- rej  out  1  one-cycle pulse when a request (e & (w|r)) arrives while busy.

## Operation
- States: CLEAR and RUN. In CLEAR, a pointer clr_ptr walks offsets 0..2^BANK_ADDR_W-1, writing zero to that offset in every bank at once (one offset per cycle). On the edge that clears offset 2^BANK_ADDR_W-1, the state moves to RUN and busy drops.
- The clear engine is driven solely by rst. RUN has no exit except rst.
- Accepted request: at an edge in RUN with e=1.
- Write (w=1): mem[bank][offset] <= din. Only the selected bank is written.
- Read (r=1): dout <= mem[bank][offset] and dout_valid <= 1 on the same edge.
- w=1 and r=1 together: both operations occur. The read is read-first, so dout returns the contents from before the write.
- e=0, or e=1 with w=r=0: no state change except that dout_valid <= 0. dout holds its value.
- A request while busy (CLEAR with e & (w|r)): no write and no read. rej <= 1 for one cycle and dout is unchanged.
- Address width rules: adr is exactly BANK_SEL_W+BANK_ADDR_W bits, so every address maps to a real word and there is no out-of-range case.

## Timing
- Reset values (at the edge where rst=1): dout=0, dout_valid=0, rej=0, busy=1, state=CLEAR, clr_ptr=0. Memory contents are not touched at this edge.
- Clear duration: exactly 2^BANK_ADDR_W edges with rst=0. busy reads 0 after the 2^BANK_ADDR_W-th such edge. With default parameters this is 512 cycles.
- Read latency: 1 cycle. dout and dout_valid update on the accepting edge.
- Write latency: 1 cycle. A read of the same address on the next edge returns the new data.
- Back-to-back reads every cycle: dout_valid stays high continuously and each dout corresponds to the previous-cycle address.
- Reset mid-operation (in CLEAR or RUN): the behaviour at the reset edge is identical to the power-up reset. The clear engine restarts from offset 0 and any request presented on that edge is dropped without rej.
- rst has priority over e, w and r on every edge.

## Test plan
- Reset then idle: hold rst for 2 cycles, then release. busy=1 for exactly 512 cycles and then drops; dout=0, dout_valid=0, rej=0 throughout.
- Clear coverage: after the first clear, write 0xA5A5 to adr 0x000, 0x1FF, 0xE00 and 0xFFF, then pulse rst and wait for busy=0. Reads of all four addresses return 0x0000.
- Bank isolation: write 0x1111 to adr 0x005 and 0x2222 to adr 0x205, then read both. Results are 0x1111 and 0x2222 with a 1-cycle latency and dout_valid high on each read.
- Simultaneous w and r: with mem[0x123]=0x00FF, present e=1, w=1, r=1, adr=0x123, din=0xBEEF. dout=0x00FF, and a subsequent read returns 0xBEEF.
- Request while busy: 10 cycles after reset release, present e=1, r=1, adr=0x010. rej pulses for 1 cycle, dout_valid=0 and dout=0. A write attempted during busy is absent after the clear completes.
- Parameter sweep: set DATA_W=8, BANK_ADDR_W=2, BANK_SEL_W=1. Clear takes 4 cycles, and writing then reading all 8 addresses with value adr^0x5A returns matching data.

Source files
------------

// File: rtl/banked_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : banked_ram_ctrl
// Purpose  : Banked single-port word store with registered read data, a
//            read-valid strobe and a post-reset clear engine that zeroes all
//            banks in parallel (one offset per cycle) before accepting access.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous active-high reset
//            e / w / r  - chip enable, write request, read request
//            adr        - word address {bank, offset}
//            din        - write data
//            dout       - registered read data (holds last read)
//            dout_valid - one-cycle pulse when dout updated by a read
//            busy       - clear engine running, requests not accepted
//            rej        - one-cycle pulse for a request seen while busy
// Revision : 1.0 - initial release
// ============================================================================
module banked_ram_ctrl #(
    parameter int DATA_W      = 16,
    parameter int BANK_ADDR_W = 9,
    parameter int BANK_SEL_W  = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              e,
    input  logic                              w,
    input  logic                              r,
    input  logic [BANK_SEL_W+BANK_ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0]                 din,
    output logic [DATA_W-1:0]                 dout,
    output logic                              dout_valid,
    output logic                              busy,
    output logic                              rej
);

    localparam int ADR_W = BANK_SEL_W + BANK_ADDR_W;
    localparam int NBANK = 1 << BANK_SEL_W;
    localparam int DEPTH = 1 << BANK_ADDR_W;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [BANK_ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]      dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   rej_q, rej_d;

    logic                   w_clearing;
    logic                   w_req;
    logic                   w_acc;
    logic [BANK_SEL_W-1:0]  w_bank;
    logic [BANK_ADDR_W-1:0] w_off;
    logic [DATA_W-1:0]      w_rd [NBANK];

    assign w_bank = adr[ADR_W-1 -: BANK_SEL_W];
    assign w_off  = adr[BANK_ADDR_W-1:0];
    assign w_req  = e & (w | r);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == S_CLEAR) begin
            // Pointer wraps to zero on the final offset; harmless since it
            // is only consulted while clearing.
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (&clr_ptr_q) begin
                state_d = S_RUN;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_clearing = (state_q == S_CLEAR);
        busy       = w_clearing;
        w_acc      = (state_q == S_RUN) & e;
    end

    // ------------------------------------------------------------------
    // Memory banks. Writes are suppressed on a reset edge so memory is left
    // untouched there; the clear engine writes every bank at once.
    // ------------------------------------------------------------------
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [DATA_W-1:0]      mem [DEPTH];
        logic                   w_we;
        logic [BANK_ADDR_W-1:0] w_wa;
        logic [DATA_W-1:0]      w_wd;

        assign w_we = ~rst & (w_clearing |
                              (w_acc & w & (w_bank == BANK_SEL_W'(b))));
        assign w_wa = w_clearing ? clr_ptr_q : w_off;
        assign w_wd = w_clearing ? '0 : din;

        always_ff @(posedge clk) begin
            if (w_we) begin
                mem[w_wa] <= w_wd;
            end
        end

        // Asynchronous array read feeding the registered dout; sampling at
        // the same edge as the write gives read-first behaviour.
        assign w_rd[b] = mem[w_off];
    end

    // ------------------------------------------------------------------
    // Read port / strobes
    // ------------------------------------------------------------------
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        rej_d        = w_clearing & w_req;
        if (w_acc & r) begin
            dout_d       = w_rd[w_bank];
            dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            rej_q        <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            rej_q        <= rej_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign rej        = rej_q;

endmodule
`default_nettype wire

// File: tb/tb_banked_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_banked_ram_ctrl
// Purpose  : Directed self-checking bench for banked_ram_ctrl, covering the
//            default configuration and a small 8-word configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_banked_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst, e, w, r;
    logic [11:0] adr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dout_valid, busy, rej;

    logic        rst_s, e_s, w_s, r_s;
    logic [2:0]  adr_s;
    logic [7:0]  din_s;
    logic [7:0]  dout_s;
    logic        dout_valid_s, busy_s, rej_s;

    int total = 0;
    int bad   = 0;
    int n;
    logic quiet;

    always #5 clk = ~clk;

    banked_ram_ctrl u_dut (
        .clk(clk), .rst(rst), .e(e), .w(w), .r(r), .adr(adr), .din(din),
        .dout(dout), .dout_valid(dout_valid), .busy(busy), .rej(rej)
    );

    banked_ram_ctrl #(.DATA_W(8), .BANK_ADDR_W(2), .BANK_SEL_W(1)) u_small (
        .clk(clk), .rst(rst_s), .e(e_s), .w(w_s), .r(r_s), .adr(adr_s),
        .din(din_s), .dout(dout_s), .dout_valid(dout_valid_s),
        .busy(busy_s), .rej(rej_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [15:0] d);
        e = 1'b1; w = 1'b1; r = 1'b0; adr = a; din = d;
        tick();
        e = 1'b0; w = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] a, input logic [15:0] exp, input string tag);
        e = 1'b1; r = 1'b1; w = 1'b0; adr = a;
        tick();
        e = 1'b0; r = 1'b0;
        chk({tag, "_data"}, dout, exp);
        chk({tag, "_valid"}, dout_valid, 1);
    endtask

    task automatic wait_clear(input int exp_n, input string tag);
        n = 0;
        while (busy && n < 600) begin
            tick();
            n++;
        end
        chk(tag, n, exp_n);
    endtask

    initial begin
        rst = 1'b1; e = 1'b0; w = 1'b0; r = 1'b0; adr = '0; din = '0;
        rst_s = 1'b1; e_s = 1'b0; w_s = 1'b0; r_s = 1'b0; adr_s = '0; din_s = '0;

        // Reset state
        tick();
        chk("rst_busy", busy, 1);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_rej", rej, 0);
        tick();
        rst = 1'b0;

        // Clear with requests injected while busy
        n = 0; quiet = 1'b1;
        repeat (10) begin
            tick(); n++;
            if (dout_valid !== 1'b0 || rej !== 1'b0 || dout !== 16'h0) quiet = 1'b0;
        end
        chk("busy_early", busy, 1);
        e = 1'b1; r = 1'b1; adr = 12'h010;
        tick(); n++;
        chk("busy_rd_rej", rej, 1);
        chk("busy_rd_valid", dout_valid, 0);
        chk("busy_rd_dout", dout, 0);
        r = 1'b0; w = 1'b1; adr = 12'h020; din = 16'h7777;
        tick(); n++;
        chk("busy_wr_rej", rej, 1);
        e = 1'b0; w = 1'b0;
        tick(); n++;
        chk("rej_pulse_end", rej, 0);
        while (busy && n < 600) begin
            tick(); n++;
            if (dout_valid !== 1'b0 || rej !== 1'b0 || dout !== 16'h0) quiet = 1'b0;
        end
        chk("clear_len_first", n, 512);
        chk("quiet_during_clear", quiet, 1);
        do_read(12'h020, 16'h0000, "busy_wr_dropped");

        // Clear coverage across a second reset
        do_write(12'h000, 16'hA5A5);
        do_write(12'h1FF, 16'hA5A5);
        do_write(12'hE00, 16'hA5A5);
        do_write(12'hFFF, 16'hA5A5);
        do_read(12'hFFF, 16'hA5A5, "pre_clear_fff");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear(512, "clear_len_second");
        do_read(12'h000, 16'h0000, "clr_000");
        do_read(12'h1FF, 16'h0000, "clr_1ff");
        do_read(12'hE00, 16'h0000, "clr_e00");
        do_read(12'hFFF, 16'h0000, "clr_fff");

        // Bank isolation with back-to-back reads
        do_write(12'h005, 16'h1111);
        do_write(12'h205, 16'h2222);
        e = 1'b1; r = 1'b1; adr = 12'h005;
        tick();
        chk("iso_b0_data", dout, 16'h1111);
        chk("iso_b0_valid", dout_valid, 1);
        adr = 12'h205;
        tick();
        chk("iso_b1_data", dout, 16'h2222);
        chk("iso_b1_valid", dout_valid, 1);
        e = 1'b0; r = 1'b0;
        tick();
        chk("idle_valid", dout_valid, 0);
        chk("idle_hold", dout, 16'h2222);

        // Simultaneous write and read is read-first
        do_write(12'h123, 16'h00FF);
        e = 1'b1; w = 1'b1; r = 1'b1; adr = 12'h123; din = 16'hBEEF;
        tick();
        e = 1'b0; w = 1'b0; r = 1'b0;
        chk("wr_rd_old", dout, 16'h00FF);
        chk("wr_rd_valid", dout_valid, 1);
        do_read(12'h123, 16'hBEEF, "wr_rd_new");

        // Reset mid-run has priority over a request on the same edge
        rst = 1'b1; e = 1'b1; r = 1'b1; adr = 12'h005;
        tick();
        rst = 1'b0; e = 1'b0; r = 1'b0;
        chk("midrst_busy", busy, 1);
        chk("midrst_dout", dout, 0);
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_rej", rej, 0);

        // Small configuration
        rst_s = 1'b0;
        n = 0;
        while (busy_s && n < 100) begin
            tick(); n++;
        end
        chk("small_clear_len", n, 4);
        for (int a = 0; a < 8; a++) begin
            e_s = 1'b1; w_s = 1'b1; adr_s = 3'(a); din_s = 8'(a) ^ 8'h5A;
            tick();
        end
        w_s = 1'b0; r_s = 1'b1;
        for (int a = 0; a < 8; a++) begin
            adr_s = 3'(a);
            tick();
            chk($sformatf("small_rd_%0d", a), dout_s, 8'(a) ^ 8'h5A);
        end
        e_s = 1'b0; r_s = 1'b0;
        chk("small_valid_last", dout_valid_s, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
